// File: rtl/store_buffer_pkg.sv
// Shared configuration for the posted-write store buffer.
// Default depth and pointer width used by store_buffer and its matcher.
package store_buffer_pkg;

    localparam int STB_DEPTH = 4;
    localparam int STB_PTR_W = $clog2(STB_DEPTH);

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Load-to-store forwarding matcher: finds the youngest valid entry
// whose word address equals the load word address.
module store_buffer_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = 30,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AW-1:0] entry_addr,
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [PW-1:0]            head,
    input  logic [AW-1:0]            ld_addr,
    output logic                     hit,
    output logic [PW-1:0]            idx
);

    logic [PW-1:0] slot;

    // Walk oldest to youngest; the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + i[PW-1:0];
            if (entry_valid[slot] && (entry_addr[slot] == ld_addr)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and DataMemory: FIFO drain,
// load forwarding from buffered stores, and a fence handshake.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = STB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              StValid,
    output logic              StReady,
    input  logic [ADDR_W-1:0] StAddr,
    input  logic [DATA_W-1:0] StData,
    input  logic              LdValid,
    input  logic [ADDR_W-1:0] LdAddr,
    output logic [DATA_W-1:0] LdData,
    output logic              LdReady,
    input  logic              FenceReq,
    output logic              FenceDone,
    input  logic              DrainEn,
    output logic              ReadValid,
    output logic [ADDR_W-1:0] ReadAddr,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              ReadReady,
    output logic              WriteValid,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              Empty,
    output logic              Full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0][WA_W-1:0]   ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [PTR_W:0]               count;

    logic             push;
    logic             pop;
    logic             hit;
    logic             fwd;
    logic [PTR_W-1:0] hit_idx;
    logic             unused_lsbs;

    assign unused_lsbs = ^{StAddr[1:0], LdAddr[1:0]};

    assign Empty      = (count == '0);
    assign Full       = (count == CNT_FULL);
    assign StReady    = !Full && !FenceReq;
    assign FenceDone  = FenceReq && Empty;
    assign push       = StValid && StReady;
    assign WriteValid = !Empty && DrainEn;
    assign pop        = WriteValid;
    assign WriteAddr  = {ent_addr[head], 2'b00};
    assign WriteData  = ent_data[head];

    assign ReadValid  = LdValid;
    assign ReadAddr   = LdAddr;

    store_buffer_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (WA_W)
    ) u_match (
        .entry_addr  (ent_addr),
        .entry_valid (ent_valid),
        .head        (head),
        .ld_addr     (LdAddr[ADDR_W-1:2]),
        .hit         (hit),
        .idx         (hit_idx)
    );

    assign fwd     = LdValid && hit;
    assign LdReady = fwd || ReadReady;

    always_comb begin
        LdData = '0;
        if (LdValid)
            LdData = fwd ? ent_data[hit_idx] : ReadData;
    end

    // Payload needs no reset: only ent_valid gates its use.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr[tail] <= StAddr[ADDR_W-1:2];
            ent_data[tail] <= StData;
        end
    end

    // Push only ever targets a slot that is not being popped: a full
    // buffer refuses pushes, an empty one cannot pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_ONE;
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_ONE;
            end
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

endmodule
